// File: rtl/stutter_scheduler.sv
// Stutter strobe generator with a fairness bound on consecutive stutters and a done flag.
// Optional pseudo-random stutter injection is compiled in with STUTTER_LFSR_EN.
module stutter_scheduler #(
  parameter int unsigned MAX_STUTTER = 3,
  parameter int unsigned STEPS       = 2,
  parameter int unsigned SW          = 4,
  parameter logic [7:0]  SEED        = 8'hA5
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 enable,
  input  logic                                 stutter_req,
  output logic                                 stutter_out,
  output logic [SW-1:0]                        step_cnt,
  output logic [$clog2(MAX_STUTTER+1)-1:0]     consec_cnt,
  output logic                                 forced,
  output logic                                 done
);

  localparam int unsigned   CW        = $clog2(MAX_STUTTER + 1);
  localparam logic [CW-1:0] MAX_C     = CW'(MAX_STUTTER);
  localparam logic [CW-1:0] CONS_ONE  = CW'(1);
  localparam logic [SW-1:0] STEPS_C   = SW'(STEPS);
  localparam logic [SW-1:0] STEP_ONE  = SW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          stutter_q, stutter_d;
  logic [SW-1:0] step_q, step_d;
  logic [CW-1:0] consec_q, consec_d;
  logic          forced_q, forced_d;
  logic          done_q;
  logic [SW-1:0] step_inc_s;
  logic          req_s;

  // Reject parameter sets that would break the bound or the step counter
  if (MAX_STUTTER < 1 || STEPS < 1 || STEPS >= (2 ** SW) || SEED == 8'h00) begin : g_bad_params
    $fatal(1, "stutter_scheduler: illegal parameter set");
  end

`ifdef STUTTER_LFSR_EN
  logic [7:0] lfsr_q;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  // LFSR advances only while the scheduler is live
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (enable && (state_q != S_DONE)) begin
      lfsr_q <= lfsr_next(lfsr_q);
    end else begin
      lfsr_q <= lfsr_q;
    end
  end

  assign req_s = stutter_req | lfsr_q[0];
`else
  assign req_s = stutter_req;
`endif

  assign step_inc_s = (step_q == STEPS_C) ? step_q : (step_q + STEP_ONE);

  // State register plus registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      stutter_q <= 1'b1;
      step_q    <= {SW{1'b0}};
      consec_q  <= {CW{1'b0}};
      forced_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      stutter_q <= stutter_d;
      step_q    <= step_d;
      consec_q  <= consec_d;
      forced_q  <= forced_d;
      done_q    <= (state_d == S_DONE);
    end
  end

  // Next-state: DONE is entered on the edge the last step is issued and left only by reset
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_DONE: begin
        state_d = S_DONE;
      end
      S_IDLE, S_RUN: begin
        if (step_d == STEPS_C) begin
          state_d = S_DONE;
        end else if (enable) begin
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output/datapath decision; the bound check outranks the stutter request
  always_comb begin
    stutter_d = 1'b1;
    step_d    = step_q;
    consec_d  = consec_q;
    forced_d  = 1'b0;
    if (state_q == S_DONE) begin
      stutter_d = 1'b1;
    end else if (!enable) begin
      stutter_d = 1'b1;
    end else if (consec_q == MAX_C) begin
      stutter_d = 1'b0;
      consec_d  = {CW{1'b0}};
      step_d    = step_inc_s;
      forced_d  = 1'b1;
    end else if (req_s) begin
      stutter_d = 1'b1;
      consec_d  = consec_q + CONS_ONE;
    end else begin
      stutter_d = 1'b0;
      consec_d  = {CW{1'b0}};
      step_d    = step_inc_s;
    end
  end

  assign stutter_out = stutter_q;
  assign step_cnt    = step_q;
  assign consec_cnt  = consec_q;
  assign forced      = forced_q;
  assign done        = done_q;

endmodule
